// File: rtl/spi_ad_slave.sv
`timescale 1ns/1ps
// spi_ad_slave: 3-wire SPI responder shadowing the ADC configuration register file.
// Oversampled by clk; 24-bit frames (16-bit command + 8 data bits, MSB first).
module spi_ad_slave #(
  parameter int DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_clk,
  input  logic        spi_cs,
  input  logic        spi_data_in,
  output logic        spi_data_out,
  output logic        spi_data_oe,
  output logic        wr_strobe,
  output logic [12:0] wr_addr,
  output logic [7:0]  wr_data,
  input  logic [12:0] loc_addr,
  output logic [7:0]  loc_q,
  output logic        busy,
  output logic        frame_err,
  input  logic        err_clr
);
  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned DEPTH_U = DEPTH;

  typedef enum logic [2:0] {IDLE, CMD, WR, RD, DONE} state_t;

  state_t      state;
  logic [1:0]  sclk_sync;
  logic [1:0]  cs_sync;
  logic [1:0]  din_sync;
  logic        sclk_q;
  logic        armed;
  logic [4:0]  cnt;
  logic [15:0] cmd;
  logic [6:0]  wr_sh;
  logic [7:0]  rd_sh;
  logic [7:0]  mem [DEPTH];

  logic        cs_hi;
  logic        din;
  logic        rise;
  logic        fall;
  logic [15:0] cmd_next;
  logic [7:0]  wr_byte;
  logic        rd_ok;
  logic        wr_ok;
  logic        last_rise;
  logic        abort;
  logic        err_set;
  logic        wr_we;

  assign cs_hi     = cs_sync[1];
  assign din       = din_sync[1];
  assign rise      = sclk_sync[1] & ~sclk_q;
  assign fall      = ~sclk_sync[1] & sclk_q;
  assign cmd_next  = {cmd[14:0], din};
  assign wr_byte   = {wr_sh, din};
  // rd_ok looks at the command as it will be after the 16th bit lands.
  assign rd_ok     = (32'(cmd_next[12:0]) < DEPTH_U) && (cmd_next[14:13] == 2'b00);
  assign wr_ok     = (32'(cmd[12:0]) < DEPTH_U) && (cmd[14:13] == 2'b00);
  assign last_rise = rise && !cs_hi && (cnt == 5'd23) && ((state == WR) || (state == RD));
  assign abort     = cs_hi && (state != IDLE) && (cnt != 5'd0) && (cnt < 5'd24);
  assign err_set   = abort || (last_rise && (cmd[14:13] != 2'b00));
  assign wr_we     = last_rise && (state == WR) && wr_ok;
  assign loc_q     = (32'(loc_addr) < DEPTH_U) ? mem[loc_addr[AW-1:0]] : 8'h00;

  // NOTE: every flop uses non-blocking (<=) so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // CS sync resets low: a CS already low at release must not look like an idle high.
      sclk_sync <= 2'b00;
      cs_sync   <= 2'b00;
      din_sync  <= 2'b00;
      sclk_q    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], spi_clk};
      cs_sync   <= {cs_sync[0], spi_cs};
      din_sync  <= {din_sync[0], spi_data_in};
      sclk_q    <= sclk_sync[1];
    end
  end

  // NOTE: the register file is reset entry by entry because its post-reset
  // contents are visible on loc_q; that keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else if (wr_we) begin
      mem[cmd[AW-1:0]] <= wr_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      armed        <= 1'b0;
      cnt          <= 5'd0;
      cmd          <= 16'h0000;
      wr_sh        <= 7'h00;
      rd_sh        <= 8'h00;
      spi_data_out <= 1'b0;
      spi_data_oe  <= 1'b0;
      wr_strobe    <= 1'b0;
      wr_addr      <= 13'h0000;
      wr_data      <= 8'h00;
      busy         <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;

      if (err_clr)      frame_err <= 1'b0;
      else if (err_set) frame_err <= 1'b1;

      if (cs_hi) begin
        // A seen-high CS arms the next frame; after reset this needs a real high.
        armed <= 1'b1;
        if (state != IDLE) begin
          state        <= IDLE;
          spi_data_oe  <= 1'b0;
          spi_data_out <= 1'b0;
          busy         <= 1'b0;
          cmd          <= 16'h0000;
          wr_sh        <= 7'h00;
          rd_sh        <= 8'h00;
        end
      end else begin
        unique case (state)
          IDLE: begin
            if (armed) begin
              state <= CMD;
              armed <= 1'b0;
              cnt   <= 5'd0;
            end
          end
          CMD: begin
            if (rise) begin
              cmd  <= cmd_next;
              cnt  <= cnt + 5'd1;
              busy <= 1'b1;
              if (cnt == 5'd15) begin
                if (cmd_next[15]) begin
                  state <= RD;
                  rd_sh <= rd_ok ? mem[cmd_next[AW-1:0]] : 8'h00;
                end else begin
                  state <= WR;
                end
              end
            end
          end
          WR: begin
            if (rise) begin
              wr_sh <= wr_byte[6:0];
              cnt   <= cnt + 5'd1;
              if (cnt == 5'd23) begin
                wr_strobe <= 1'b1;
                wr_addr   <= cmd[12:0];
                wr_data   <= wr_byte;
                state     <= DONE;
              end
            end
          end
          RD: begin
            if (fall) begin
              spi_data_oe  <= 1'b1;
              spi_data_out <= rd_sh[7];
              rd_sh        <= {rd_sh[6:0], 1'b0};
            end
            if (rise) begin
              cnt <= cnt + 5'd1;
              if (cnt == 5'd23) state <= DONE;
            end
          end
          DONE: begin
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
